// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature speed estimator.
package quad_pkg;

    localparam int VEL_W_DEF = 16;
    localparam int PER_W_DEF = 24;

    localparam logic [0:0] PRIME = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    localparam logic [0:0] SYNC = 1'b0;
    localparam logic [0:0] MEAS = 1'b1;

    // Clamp a signed 32-bit delta into a w-bit signed range; caller truncates.
    function automatic logic [31:0] sat_signed(input logic [31:0] d, input int w);
        logic signed [31:0] ds;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        ds = signed'(d);
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (ds > hi) return hi;
        if (ds < lo) return lo;
        return ds;
    endfunction

endpackage

// File: rtl/quad_period_timer.sv
// Edge-to-edge period measurement with stall detection.
module quad_period_timer
    import quad_pkg::*;
#(
    parameter int PER_W       = PER_W_DEF,
    parameter int TIMEOUT_CYC = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cnt,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             stalled
);

    localparam logic [PER_W-1:0] TO = PER_W'(TIMEOUT_CYC);

    logic [0:0]       state;
    logic [31:0]      cnt_q;
    logic [PER_W-1:0] per_cnt;
    logic             chg;

    assign chg = (cnt != cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SYNC;
            cnt_q        <= '0;
            per_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            cnt_q        <= cnt;
            period_valid <= 1'b0;
            if (state == SYNC) begin
                // First change only opens a measurement; its interval is partial.
                if (chg) begin
                    per_cnt <= PER_W'(1);
                    state   <= MEAS;
                    stalled <= 1'b0;
                end else if (per_cnt < TO) begin
                    per_cnt <= per_cnt + 1'b1;
                end else if (!stalled) begin
                    stalled      <= 1'b1;
                    period       <= '1;
                    period_valid <= 1'b1;
                end
            end else begin
                if (chg) begin
                    period       <= per_cnt;
                    period_valid <= 1'b1;
                    per_cnt      <= PER_W'(1);
                end else if (per_cnt >= TO) begin
                    stalled      <= 1'b1;
                    period       <= '1;
                    period_valid <= 1'b1;
                    state        <= SYNC;
                end else begin
                    per_cnt <= per_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/quad_speed_estimator.sv
// Fixed-window velocity and edge-period estimator fed by the decoder count.
module quad_speed_estimator
    import quad_pkg::*;
#(
    parameter int SAMPLE_DIV  = 100000,
    parameter int VEL_W       = VEL_W_DEF,
    parameter int PER_W       = PER_W_DEF,
    parameter int TIMEOUT_CYC = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cnt,
    output logic [VEL_W-1:0] vel,
    output logic             vel_valid,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             stalled
);

    localparam int DW = $clog2(SAMPLE_DIV);

    logic [DW-1:0] div_cnt;
    logic [0:0]    vstate;
    logic [31:0]   cnt_prev;
    logic          tick;

    assign tick = (div_cnt == DW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            vstate    <= PRIME;
            cnt_prev  <= '0;
            vel       <= '0;
            vel_valid <= 1'b0;
        end else begin
            vel_valid <= 1'b0;
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                cnt_prev <= cnt;
                // Modular subtract keeps the delta right across the 2^31 wrap.
                if (vstate == PRIME) begin
                    vstate <= RUN;
                end else begin
                    vel       <= VEL_W'(sat_signed(cnt - cnt_prev, VEL_W));
                    vel_valid <= 1'b1;
                end
            end
        end
    end

    quad_period_timer #(
        .PER_W       (PER_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_period (
        .clk          (clk),
        .rst          (rst),
        .cnt          (cnt),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled)
    );

endmodule

// File: tb/tb_quad_speed_estimator.sv
// Directed bench for quad_speed_estimator: velocity, period, stall, wrap, saturation.
module tb_quad_speed_estimator;

    localparam int SD = 100;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cnt = '0;

    logic [15:0] vel;
    logic        vel_valid;
    logic [23:0] period;
    logic        period_valid;
    logic        stalled;

    logic [3:0]  vel_s;
    logic        vv_s;
    logic [23:0] per_s;
    logic        pv_s;
    logic        st_s;

    int n_cmp = 0;
    int n_bad = 0;
    int pv_n  = 0;
    int step  = 0;
    int ival  = 1;
    int ph    = 0;
    int n;
    int pvb;

    quad_speed_estimator #(
        .SAMPLE_DIV(SD), .VEL_W(16), .PER_W(24), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .cnt(cnt),
        .vel(vel), .vel_valid(vel_valid),
        .period(period), .period_valid(period_valid),
        .stalled(stalled)
    );

    quad_speed_estimator #(
        .SAMPLE_DIV(SD), .VEL_W(4), .PER_W(24), .TIMEOUT_CYC(TO)
    ) dut_s (
        .clk(clk), .rst(rst), .cnt(cnt),
        .vel(vel_s), .vel_valid(vv_s),
        .period(per_s), .period_valid(pv_s),
        .stalled(st_s)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (period_valid) pv_n++;
        if (step != 0) begin
            ph++;
            if (ph >= ival) begin
                ph  = 0;
                cnt = cnt + 32'(step);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_vel(input int lim, output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!vel_valid && k < lim);
        if (!vel_valid) check("vel_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic skip_vel(input int cnt_w);
        int k;
        for (int i = 0; i < cnt_w; i++) wait_vel(400, k);
    endtask

    task automatic drive(input int s, input int iv);
        @(negedge clk);
        ph   = 0;
        ival = iv;
        step = s;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_vel", 32'(vel), 32'd0);
        check("rst_vv", 32'(vel_valid), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_pv", 32'(period_valid), 32'd0);
        check("rst_stalled", 32'(stalled), 32'd0);

        // Idle count: first window result at cycle 2*SD+1, then stall
        @(negedge clk);
        rst  = 1'b0;
        pv_n = 0;
        wait_vel(1000, n);
        check("first_vv_cycle", 32'(n + 1), 32'(2 * SD + 1));
        check("first_vel", 32'($signed(vel)), 32'd0);
        repeat (900) @(negedge clk);
        check("idle_stalled", 32'(stalled), 32'd1);
        check("idle_period", 32'(period), 32'hFFFFFF);
        check("idle_pv_count", 32'(pv_n), 32'd1);

        // Up 1 per 10 cycles
        drive(1, 10);
        skip_vel(2);
        for (int i = 0; i < 2; i++) begin
            wait_vel(400, n);
            check("up10_vel", 32'($signed(vel)), 32'd10);
        end
        check("up10_period", 32'(period), 32'd10);
        check("up10_stalled", 32'(stalled), 32'd0);

        // Down 1 per 4 cycles
        drive(-1, 4);
        skip_vel(2);
        wait_vel(400, n);
        check("dn4_vel", 32'($signed(vel)), -32'sd25);
        check("dn4_period", 32'(period), 32'd4);

        // Wrap across 0x7FFFFFFF -> 0x80000000
        drive(0, 1);
        @(negedge clk);
        cnt  = 32'h7FFF_FFD8;
        ph   = 0;
        ival = 10;
        step = 1;
        skip_vel(2);
        for (int i = 0; i < 4; i++) begin
            wait_vel(400, n);
            check("wrap_vel", 32'($signed(vel)), 32'd10);
            check("wrap_vel_sat4", 32'($signed(vel_s)), 32'd7);
        end
        check("wrap_crossed", 32'(cnt[31]), 32'd1);

        // Saturation at 1 count per cycle
        drive(1, 1);
        skip_vel(2);
        wait_vel(400, n);
        check("up1_vel", 32'($signed(vel)), 32'd100);
        check("up1_vel_sat4", 32'($signed(vel_s)), 32'd7);
        check("up1_period", 32'(period), 32'd1);
        drive(-1, 1);
        skip_vel(2);
        wait_vel(400, n);
        check("dn1_vel", 32'($signed(vel)), -32'sd100);
        check("dn1_vel_sat4", 32'($signed(vel_s)), -32'sd8);

        // Stall then resume
        drive(0, 1);
        repeat (2000) @(negedge clk);
        check("stall_stalled", 32'(stalled), 32'd1);
        check("stall_period", 32'(period), 32'hFFFFFF);
        @(negedge clk);
        pvb = pv_n;
        cnt = cnt + 32'd1;
        repeat (7) @(negedge clk);
        check("resume_stalled", 32'(stalled), 32'd0);
        check("resume_no_pv", 32'(pv_n), 32'(pvb));
        cnt = cnt + 32'd1;
        repeat (3) @(negedge clk);
        check("resume_period", 32'(period), 32'd7);
        check("resume_pv", 32'(pv_n), 32'(pvb + 1));

        // Reset mid-window with a nonzero held count
        drive(1, 10);
        repeat (150) @(negedge clk);
        rst  = 1'b1;
        step = 0;
        @(posedge clk);
        #1;
        check("mrst_vel", 32'(vel), 32'd0);
        check("mrst_vel4", 32'(vel_s), 32'd0);
        check("mrst_vv", 32'(vel_valid), 32'd0);
        check("mrst_period", 32'(period), 32'd0);
        check("mrst_pv", 32'(period_valid), 32'd0);
        check("mrst_stalled", 32'(stalled), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        pv_n = 0;
        wait_vel(1000, n);
        check("mrst_vv_cycle", 32'(n + 1), 32'(2 * SD + 1));
        check("mrst_vel_after", 32'($signed(vel)), 32'd0);
        @(negedge clk);
        check("mrst_no_stale_pv", 32'(pv_n), 32'd0);
        check("mrst_stalled_after", 32'(stalled), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
